button_conditioner: RTL

- Input-conditioning stage directly upstream of the paddle controller.
- Takes the four raw, asynchronous player push-buttons and synchronises them to clk.
- Debounces each button against the shared 1 ms timebase (clk_1ms from clock_divider).
- Per button, produces a clean level, one-cycle press/release pulses and a typematic repeat pulse. The paddle logic consumes these instead of raw pins.

---
 rtl/pong_pkg.sv | 36 +++
 rtl/btn_debounce_ch.sv | 145 ++++++++++++++
 rtl/button_conditioner.sv | 72 +++++++
 3 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared constants, repeat-FSM state type and small helper
//               functions for the pong input-conditioning blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Number of player buttons on the reference board.
  localparam int N_BTN_DEFAULT = 4;

  // Milliseconds represented by one timebase tick from clock_divider.
  localparam int MS_PER_TICK = 1;

  // Typematic repeat state per button channel.
  typedef enum logic [1:0] {
    RP_IDLE  = 2'd0,
    RP_DELAY = 2'd1,
    RP_RATE  = 2'd2
  } rp_state_t;

  // Convert a millisecond interval into a tick count, never below one tick.
  function automatic int ms_to_ticks(input int ms);
    int t;
    t = ms / MS_PER_TICK;
    if (t < 1) t = 1;
    return t;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_ch
// Description : One button channel: tick-sampled debounce, registered
//               press/release pulses and a typematic repeat FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_ch
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 300,
  parameter int REPEAT_RATE_MS  = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_sync,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int DB_TICKS   = ms_to_ticks(DEBOUNCE_MS);
  localparam int DLY_TICKS  = ms_to_ticks(REPEAT_DELAY_MS);
  localparam int RATE_TICKS = ms_to_ticks(REPEAT_RATE_MS);
  localparam int DB_W       = $clog2(DB_TICKS + 1);
  localparam int RP_W       = $clog2(max_int(DLY_TICKS, RATE_TICKS) + 1);

  // Terminal counts: the event fires on the tick where the counter holds these.
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_TICKS - 1);
  localparam logic [RP_W-1:0] DLY_LAST  = RP_W'(DLY_TICKS - 1);
  localparam logic [RP_W-1:0] RATE_LAST = RP_W'(RATE_TICKS - 1);

  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] db_cnt_nxt;
  logic [RP_W-1:0] rp_cnt;
  logic [RP_W-1:0] rp_cnt_nxt;
  rp_state_t       state;
  rp_state_t       state_nxt;
  logic            level_nxt;
  logic            press_nxt;
  logic            release_nxt;
  logic            repeat_nxt;
  logic            accept_rise;
  logic            accept_fall;

  // State and output registers; pulses are registered so they line up with
  // the first cycle in which btn_level shows the new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RP_IDLE;
      db_cnt      <= '0;
      rp_cnt      <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      state       <= state_nxt;
      db_cnt      <= db_cnt_nxt;
      rp_cnt      <= rp_cnt_nxt;
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      btn_repeat  <= repeat_nxt;
    end
  end

  // Debounce, edge detection and repeat scheduling; a release always wins
  // over a repeat that would otherwise fire in the same cycle.
  always_comb begin
    state_nxt   = state;
    db_cnt_nxt  = db_cnt;
    rp_cnt_nxt  = rp_cnt;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    repeat_nxt  = 1'b0;
    accept_rise = 1'b0;
    accept_fall = 1'b0;

    // Count consecutive ticks on which the synchronised input disagrees with
    // the accepted level; any agreeing tick restarts the qualification.
    if (tick) begin
      if (btn_sync == btn_level) begin
        db_cnt_nxt = '0;
      end else if (db_cnt == DB_LAST) begin
        level_nxt   = btn_sync;
        db_cnt_nxt  = '0;
        accept_rise = btn_sync;
        accept_fall = ~btn_sync;
      end else begin
        db_cnt_nxt = db_cnt + DB_W'(1);
      end
    end

    press_nxt   = accept_rise;
    release_nxt = accept_fall;

    case (state)
      RP_IDLE: begin
        if (accept_rise) begin
          state_nxt  = RP_DELAY;
          rp_cnt_nxt = '0;
          repeat_nxt = 1'b1;
        end
      end
      RP_DELAY: begin
        if (tick) begin
          if (rp_cnt == DLY_LAST) begin
            state_nxt  = RP_RATE;
            rp_cnt_nxt = '0;
            repeat_nxt = 1'b1;
          end else begin
            rp_cnt_nxt = rp_cnt + RP_W'(1);
          end
        end
      end
      RP_RATE: begin
        if (tick) begin
          if (rp_cnt == RATE_LAST) begin
            rp_cnt_nxt = '0;
            repeat_nxt = 1'b1;
          end else begin
            rp_cnt_nxt = rp_cnt + RP_W'(1);
          end
        end
      end
      default: begin
        state_nxt  = RP_IDLE;
        rp_cnt_nxt = '0;
      end
    endcase

    if (accept_fall) begin
      state_nxt  = RP_IDLE;
      rp_cnt_nxt = '0;
      repeat_nxt = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Synchronises the raw player buttons, derives a one-clock 1 ms
//               tick and feeds one debounce/repeat channel per button.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
  import pong_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 300,
  parameter int REPEAT_RATE_MS  = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_1ms,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  logic             clk_1ms_d;
  logic             tick;
  logic [N_BTN-1:0] btn_meta;
  logic [N_BTN-1:0] btn_sync;

  // Delay the timebase by one clock for rising-edge detection, so either a
  // square wave or a single-cycle pulse yields exactly one tick per period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_1ms_d <= 1'b0;
    end else begin
      clk_1ms_d <= clk_1ms;
    end
  end

  assign tick = clk_1ms & ~clk_1ms_d;

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_MS     (DEBOUNCE_MS),
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_RATE_MS  (REPEAT_RATE_MS)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .btn_sync    (btn_sync[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i])
    );
  end

endmodule
`default_nettype wire
